// File: rtl/frontend_command_definition_pkg.sv
// Shared definitions for the frontend command path: address geometry defaults,
// read-hazard FSM encoding and the write-queue slot layout.
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif

package frontend_command_definition_pkg;

  localparam int WQ_SLOTS       = 8;
  localparam int DEF_ADDR_WIDTH = `ROW_ADDR_BITS + `COL_ADDR_BITS + `BANK_ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2,
    ISSUE = 2'd3
  } hazard_state_t;

  // One pending write slot; the address is {bank, row, col}.
  typedef struct packed {
    logic                      valid;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } wq_entry_t;

endpackage

// File: rtl/raw_addr_cmp.sv
// Combinational compare of the captured read address against all pending
// write slots; reports the per-slot match vector and the youngest hit.
module raw_addr_cmp
  import frontend_command_definition_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH:0]   slots [WQ_SLOTS],
  input  logic [ADDR_WIDTH-1:0] addr_q,
  output logic [WQ_SLOTS-1:0]   match,
  output logic                  any_hit,
  output logic [2:0]            youngest_idx
);

  // Invalid slots never match, whatever their address bits hold.
  always_comb begin
    for (int k = 0; k < WQ_SLOTS; k++) begin
      match[k] = slots[k][ADDR_WIDTH] && (slots[k][ADDR_WIDTH-1:0] == addr_q);
    end
  end

  assign any_hit = |match;

  // NOTE: the default assignment ahead of the loop keeps this block latch-free.
  always_comb begin
    youngest_idx = '0;
    for (int k = 0; k < WQ_SLOTS; k++) begin
      if (match[k]) youngest_idx = 3'(k);
    end
  end

endmodule

// File: rtl/raw_hazard_checker.sv
// Read-after-write hazard gate: holds one captured read until no valid pending
// write targets the same address, then issues it on a valid/ready handshake.
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif

module raw_hazard_checker
  import frontend_command_definition_pkg::*;
#(
  parameter int ADDR_WIDTH = `ROW_ADDR_BITS + `COL_ADDR_BITS + `BANK_ADDR_BITS,
  parameter int HOLD_MAX   = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_valid,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_ready,
  input  logic [ADDR_WIDTH:0]   i_wq_addr_0,
  input  logic [ADDR_WIDTH:0]   i_wq_addr_1,
  input  logic [ADDR_WIDTH:0]   i_wq_addr_2,
  input  logic [ADDR_WIDTH:0]   i_wq_addr_3,
  input  logic [ADDR_WIDTH:0]   i_wq_addr_4,
  input  logic [ADDR_WIDTH:0]   i_wq_addr_5,
  input  logic [ADDR_WIDTH:0]   i_wq_addr_6,
  input  logic [ADDR_WIDTH:0]   i_wq_addr_7,
  output logic                  o_rd_valid,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic                  i_rd_ready,
  output logic                  o_hazard,
  output logic                  o_drain_req,
  output logic [2:0]            o_hit_idx,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt,
  output logic                  o_timeout
);

  // Wide enough to hold HOLD_MAX so the timeout compare is always reachable.
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  hazard_state_t         state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [ADDR_WIDTH:0]   slots [WQ_SLOTS];
  logic [WQ_SLOTS-1:0]   match;
  logic                  any_hit;
  logic [2:0]            youngest_idx;

  assign slots[0] = i_wq_addr_0;
  assign slots[1] = i_wq_addr_1;
  assign slots[2] = i_wq_addr_2;
  assign slots[3] = i_wq_addr_3;
  assign slots[4] = i_wq_addr_4;
  assign slots[5] = i_wq_addr_5;
  assign slots[6] = i_wq_addr_6;
  assign slots[7] = i_wq_addr_7;

  raw_addr_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cmp (
    .slots        (slots),
    .addr_q       (addr_q),
    .match        (match),
    .any_hit      (any_hit),
    .youngest_idx (youngest_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      hold_cnt    <= '0;
      o_hit_idx   <= '0;
      o_stall_cnt <= '0;
      o_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_rd_valid && o_rd_ready) begin
            addr_q   <= i_rd_addr;
            hold_cnt <= '0;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (any_hit) begin
            o_hit_idx <= youngest_idx;
            state     <= HOLD;
          end else begin
            state <= ISSUE;
          end
        end
        HOLD: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + HOLD_W'(1);
          if (o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + CNT_WIDTH'(1);
          if (hold_cnt == HOLD_W'(HOLD_MAX - 1)) o_timeout <= 1'b1;
          if (!any_hit) state <= ISSUE;
        end
        ISSUE: begin
          if (i_rd_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_rd_ready  = i_rst_n && (state == IDLE);
  assign o_rd_valid  = (state == ISSUE);
  assign o_hazard    = (state == HOLD);
  assign o_drain_req = (state == HOLD);
  assign o_rd_addr   = addr_q;

endmodule
